// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 peripheral writing five 8-bit registers from 16-bit frames.
// Define SPI_READBACK_EN to return register contents on cipo during read frames.
module spi_reg_writer #(
  parameter int MAX_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, next;
  logic [SYNC_STAGES:0] sclk_q, copi_q, ncs_q;
  logic [15:0] sr;
  logic [4:0] cnt;
  logic [7:0] regs [0:4];
  logic clear, sample, write;
  function automatic logic mapped(input logic [6:0] a);
    return int'(a) <= MAX_ADDR && a < 7'd5;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      copi_q <= {copi_q[SYNC_STAGES-1:0], copi};
      ncs_q  <= {ncs_q[SYNC_STAGES-1:0], ncs};
    end
  wire sclk_s    = sclk_q[SYNC_STAGES-1];
  wire sclk_rise = sclk_s & ~sclk_q[SYNC_STAGES];
  wire ncs_s     = ncs_q[SYNC_STAGES-1];
  wire ncs_fall  = ~ncs_s & ncs_q[SYNC_STAGES];
  wire ncs_rise  = ncs_s & ~ncs_q[SYNC_STAGES];
  wire ncs_edge  = ncs_fall | ncs_rise;
  // copi is stable long before the sclk edge, so the older history copy gives extra margin
  wire copi_s    = copi_q[SYNC_STAGES];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = ncs_fall ? SHIFT : state == SHIFT ? (ncs_rise ? COMMIT : SHIFT) : IDLE;
  always_comb begin
    clear  = ncs_fall;
    sample = state == SHIFT && sclk_rise && !ncs_edge && !ncs_s;
    write  = state == COMMIT && cnt == 5'd16 && sr[15] && mapped(sr[14:8]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (sample) begin
      sr  <= {sr[14:0], copi_s};
      cnt <= cnt == 5'd17 ? cnt : cnt + 5'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '{default: '0};
    else if (write) regs[sr[10:8]] <= sr[7:0];
  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];
`ifdef SPI_READBACK_EN
  logic [7:0] rd;
  logic rd_on, cipo_q;
  wire sclk_fall = ~sclk_s & sclk_q[SYNC_STAGES];
  wire [6:0] rd_addr = {sr[5:0], copi_s};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd     <= '0;
      rd_on  <= 1'b0;
      cipo_q <= 1'b0;
    end else if (ncs_edge) begin
      rd     <= '0;
      rd_on  <= 1'b0;
      cipo_q <= 1'b0;
    end else if (sample && cnt == 5'd7 && !sr[6]) begin
      rd    <= mapped(rd_addr) ? regs[rd_addr[2:0]] : 8'h00;
      rd_on <= 1'b1;
    end else if (rd_on && sclk_fall && !ncs_s) begin
      cipo_q <= rd[7];
      rd     <= {rd[6:0], 1'b0};
    end
  assign cipo = cipo_q & ~ncs;
`else
  assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: directed and random SPI frames checked against a frame-level register model.
module tb_spi_reg_writer;
  localparam int S = 2;
  localparam int H = 8;
  logic clk = 0, rst = 1, sclk = 0, copi = 0, ncs = 1;
  logic cipo;
  logic [7:0] o0, o1, p0, p1, pd;
  logic [7:0] model [0:7];
  logic [23:0] rx;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  spi_reg_writer #(.MAX_ADDR(4), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(o0), .en_reg_out_15_8(o1), .en_reg_pwm_7_0(p0),
    .en_reg_pwm_15_8(p1), .pwm_duty_cycle(pd)
  );
  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, "/out_7_0"}, {8'h0, o0}, {8'h0, model[0]});
    chk({tag, "/out_15_8"}, {8'h0, o1}, {8'h0, model[1]});
    chk({tag, "/pwm_7_0"}, {8'h0, p0}, {8'h0, model[2]});
    chk({tag, "/pwm_15_8"}, {8'h0, p1}, {8'h0, model[3]});
    chk({tag, "/duty"}, {8'h0, pd}, {8'h0, model[4]});
  endtask
  task automatic shift_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wclk(H);
      rx = {rx[22:0], cipo};
      sclk = 1;
      wclk(H);
      sclk = 0;
    end
  endtask
  // A frame commits only if it is exactly 16 bits, a write, and to a mapped address
  task automatic frame(input logic [23:0] v, input int n);
    rx = '0;
    ncs = 0;
    wclk(H);
    shift_bits(v, n);
    wclk(H);
    ncs = 1;
    wclk(S + 2);
`ifdef SPI_READBACK_EN
    if (n == 16 && !v[15])
      chk("readback", {8'h0, rx[7:0]}, {8'h0, v[14:8] <= 7'd4 ? model[v[10:8]] : 8'h00});
`else
    chk("cipo_zero", rx[15:0], 16'h0);
`endif
    chk("cipo_idle", {15'h0, cipo}, 16'h0);
    if (n == 16 && v[15] && v[14:8] <= 7'd4) model[v[10:8]] = v[7:0];
  endtask
  initial begin
    logic [23:0] v;
    int n;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    wclk(3);
    chk_regs("in_reset");
    chk("cipo_reset", {15'h0, cipo}, 16'h0);
    rst = 0;
    wclk(3);
    frame(24'h80F0, 16);
    chk_regs("w00_F0");
    frame(24'h8480, 16);
    chk_regs("w04_80");
    frame(24'h85FF, 16);
    chk_regs("w05_unmapped");
    frame({8'h82, 7'h55}, 15);
    chk_regs("short15");
    frame({8'h82, 9'h1AB}, 17);
    chk_regs("long17");
    frame(24'h0233, 16);
    chk_regs("read_discard");
    rx = '0;
    ncs = 0;
    wclk(H);
    shift_bits(24'h83AA >> 7, 9);
    rst = 1;
    wclk(2);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    chk_regs("mid_rst");
    chk("cipo_mid_rst", {15'h0, cipo}, 16'h0);
    rst = 0;
    wclk(2);
    ncs = 1;
    wclk(S + 2);
    chk_regs("post_rst");
    frame(24'h8355, 16);
    chk_regs("w03_55");
    rx = '0;
    ncs = 0;
    wclk(H);
    shift_bits(24'h81FF >> 10, 6);
    ncs = 1;
    wclk(2);
    ncs = 0;
    wclk(H);
    shift_bits(24'h813C, 16);
    wclk(H);
    ncs = 1;
    wclk(S + 2);
    model[1] = 8'h3C;
    chk_regs("restart_w01");
    frame(24'h845A, 16);
    chk_regs("w04_5A");
    frame(24'h0400, 16);
    chk_regs("read04");
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(14, 18);
      v = 24'($urandom) & ((24'h1 << n) - 24'h1);
      if (n == 16) v[15] = $urandom_range(0, 3) != 0;
      frame(v, n);
      chk_regs("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_reg_writer.md
SPI_REG_WRITER -- requirements
Module: spi_reg_writer

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4: highest writable register address.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count on sclk, copi and ncs.
REQ-003 SHALL have port clk, input, 1: single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1: SPI serial clock, asynchronous to clk, mode 0.
REQ-006 SHALL have port copi, input, 1: SPI controller-out data, MSB first.
REQ-007 SHALL have port ncs, input, 1: SPI chip select, active-low.
REQ-008 SHALL have port cipo, output, 1: SPI peripheral-out readback data.
REQ-009 SHALL have outputs en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each 8 bits, registered, at addresses 0x00 to 0x04 respectively.

Function
REQ-010 SHALL pass sclk, copi and ncs through SYNC_STAGES flops plus one history flop, and SHALL act only on the synchronized edges.
REQ-011 SHALL support sclk rates up to clk/8; faster sclk gives undefined results.
REQ-012 SHALL implement the states IDLE, SHIFT and COMMIT.
- IDLE -> SHIFT on a synchronized ncs falling edge.
- SHIFT -> COMMIT on a synchronized ncs rising edge.
- COMMIT -> IDLE unconditionally after 1 clk.
REQ-013 In SHIFT, SHALL sample copi on each synchronized sclk rising edge into a 16-bit shift register.
REQ-014 In SHIFT, SHALL count bits with a 5-bit saturating counter that stops at 17.
REQ-015 The frame format SHALL be: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-016 In COMMIT, SHALL update the addressed register only if all of these hold: bit count == 16, R/W = 1, address <= MAX_ADDR.
REQ-017 SHALL discard, with no register change, any frame of fewer or more than 16 bits, any write to address > MAX_ADDR, and any read frame.
REQ-018 A register update SHALL appear on its output at most SYNC_STAGES+2 clk cycles after ncs rises at the pin.
REQ-019 Outputs SHALL otherwise hold their values indefinitely.
REQ-020 On a synchronized ncs falling edge in any state other than IDLE, SHALL abandon the current frame and restart SHIFT with the bit count cleared.
REQ-021 SHALL ignore sclk edges while ncs is high.
REQ-022 When sclk and ncs edges are detected in the same clk cycle, the ncs edge SHALL take priority and the sclk edge SHALL be ignored.
REQ-023 cipo SHALL be 0 whenever ncs is high and whenever SPI_READBACK_EN is not defined.

Reset
REQ-024 While rst = 1, SHALL clear all five register outputs, the shift register, the bit counter and cipo to 0, asynchronously.
REQ-025 While rst = 1, SHALL force the state to IDLE and load all synchronizer flops with their idle values (ncs = 1, sclk = 0, copi = 0).
REQ-026 A reset mid-frame SHALL abandon the frame.
REQ-027 After reset release, SHALL accept a new frame only after the next synchronized ncs falling edge.

Configuration
REQ-028 The macro SPI_READBACK_EN SHALL enable register readback.
REQ-029 With SPI_READBACK_EN defined, in a frame with R/W = 0, SHALL latch the address on the 8th sclk rising edge.
REQ-030 With SPI_READBACK_EN defined, SHALL drive cipo with register[address] bit7 on the next synchronized sclk falling edge.
REQ-031 With SPI_READBACK_EN defined, SHALL shift out bits 6..0 on the following falling edges.
REQ-032 With SPI_READBACK_EN defined, an unmapped address SHALL return 0x00.
REQ-033 Without SPI_READBACK_EN, SHALL omit the readback logic and tie cipo to 0; read frames SHALL be discarded per REQ-017.

Verification
REQ-034 Bench SHALL cover: after reset, write frame 0x80,0xF0 -> en_reg_out_7_0 = 0xF0 within SYNC_STAGES+2 clk of ncs rise; other registers stay 0x00.
REQ-035 Bench SHALL cover: write frame 0x84,0x80 -> pwm_duty_cycle = 0x80; a following write frame 0x85,0xFF -> no output changes.
REQ-036 Bench SHALL cover: 15-bit frame and 17-bit frame, both targeting 0x82 -> en_reg_pwm_7_0 unchanged.
REQ-037 Bench SHALL cover: rst = 1 asserted after 9 bits of frame 0x83,0xAA, then a clean write frame 0x83,0x55 -> en_reg_pwm_15_8 = 0x55.
REQ-038 Bench SHALL cover: ncs re-falling after 6 bits, followed by full frame 0x81,0x3C -> en_reg_out_15_8 = 0x3C.
REQ-039 Bench SHALL cover, with SPI_READBACK_EN defined: write 0x84,0x5A, then read frame 0x04,0x00 -> cipo bits 8..15 = 0x5A, MSB first; without SPI_READBACK_EN, cipo = 0 throughout.
